// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit:
//   - op_e    : funct3 operation encodings (RV32M/RV64M order)
//   - state_e : FSM state encoding, also exported on the debug port
//   - helpers that classify an op (divide family, operand signedness)
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide family lives in the upper half of the encoding space.
    function automatic logic op_is_div(input op_e op);
        return op[2];
    endfunction

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM. MUL only keeps
    // the low half of the product, which is identical either way, so it runs
    // unsigned.
    function automatic logic op_rs1_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV)  || (op == OP_REM);
    endfunction

    function automatic logic op_rs2_signed(input op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// -----------------------------------------------------------------------------
// muldiv_signfix
// Combinational conditional two's-complement negate.
//   a_i   [W-1:0] : value in
//   neg_i         : 1 = output -a_i, 0 = output a_i
//   y_o   [W-1:0] : result
// Used both to take operand magnitudes and to restore the result sign.
// -----------------------------------------------------------------------------
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? ((~a_i) + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RISC-V M-extension multiply/divide unit. One product/quotient bit
// per cycle (radix-2 shift-add multiply, restoring divide) on operand
// magnitudes, sign correction applied when the result is presented.
//
// Ports
//   clk, rst         : clock, asynchronous active-high reset
//   start            : request, taken when ready=1 and kill=0
//   funct3           : operation (see muldiv_pkg::op_e)
//   rs1, rs2         : operands, captured on the accepting edge
//   kill             : flush; aborts CALC/DONE, blocks a start in IDLE
//   ready            : IDLE
//   busy             : CALC or DONE
//   done             : one-cycle result-valid pulse
//   r, dz            : result and divide-by-zero flag; held until next done
//   dbg_state        : current FSM state (muldiv_pkg::state_e)
//
// Handshake: a request is a start/ready pair. It is taken on a rising edge
// where start=1, ready=1 and kill=0; there is no queueing, start is ignored
// at any other time, and the result is reported exactly once by done.
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] r,
    output logic            dz,
    output logic [1:0]      dbg_state
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    op_e               op_q, op_d, op_in;
    // hi/lo: product {hi,lo} for multiply; remainder (hi) and
    // dividend-shifting-into-quotient (lo) for divide.
    logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
    // m: multiplicand magnitude or divisor magnitude.
    logic [XLEN-1:0]   m_q, m_d;
    logic              neg_q, neg_d;     // negate result at presentation
    logic              dzp_q, dzp_d;     // pending dz for the current op
    logic [XLEN-1:0]   r_q, r_d;
    logic              dz_q, dz_d;

    logic              accept;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;

    logic              is_div_q;
    logic [XLEN-1:0]   add_x, add_y, add_s;
    logic              add_cin, add_co;
    logic              div_ge;

    logic [2*XLEN-1:0] res_in, res_fix;
    logic [XLEN-1:0]   res_sel;

    assign op_in  = op_e'(funct3);
    assign accept = (state_q == ST_IDLE) && start && !kill;

    // ---------------- operand magnitudes ----------------
    assign neg_a = op_rs1_signed(op_in) && rs1[XLEN-1];
    assign neg_b = op_rs2_signed(op_in) && rs2[XLEN-1];

    muldiv_signfix #(.W(XLEN)) u_mag_a (.a_i(rs1), .neg_i(neg_a), .y_o(mag_a));
    muldiv_signfix #(.W(XLEN)) u_mag_b (.a_i(rs2), .neg_i(neg_b), .y_o(mag_b));

    // Special divides are resolved at accept and skip CALC entirely.
    assign div_zero = op_is_div(op_in) && (rs2 == '0);
    assign div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                      (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);

    // ---------------- shared adder/subtractor ----------------
    // Multiply: hi + (lo[0] ? m : 0).
    // Divide:   {hi, lo_msb} - m using only the low XLEN bits; the dropped
    //           top bit (hi msb) is folded into the compare below.
    assign is_div_q = op_is_div(op_q);
    assign add_x    = is_div_q ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : hi_q;
    assign add_y    = is_div_q ? ~m_q : (lo_q[0] ? m_q : '0);
    assign add_cin  = is_div_q;
    assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{XLEN{1'b0}}, add_cin};
    // Shifted remainder >= divisor when the 33rd bit is set or no borrow.
    assign div_ge   = hi_q[XLEN-1] || add_co;

    // ---------------- result correction ----------------
    always_comb begin
        res_in = {hi_q, lo_q};
        unique case (op_q)
            OP_DIV, OP_DIVU: res_in = {{XLEN{1'b0}}, lo_q};
            OP_REM, OP_REMU: res_in = {{XLEN{1'b0}}, hi_q};
            default:         res_in = {hi_q, lo_q};
        endcase
    end

    // Negating the zero-extended quotient/remainder at 2*XLEN gives the
    // correct XLEN-bit two's complement in the low half.
    muldiv_signfix #(.W(2*XLEN)) u_res_fix (.a_i(res_in), .neg_i(neg_q), .y_o(res_fix));

    assign res_sel = ((op_q == OP_MUL) || is_div_q) ? res_fix[XLEN-1:0]
                                                    : res_fix[2*XLEN-1:XLEN];

    // ---------------- FSM + datapath next state ----------------
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        m_d     = m_q;
        neg_d   = neg_q;
        dzp_d   = dzp_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    op_d  = op_in;
                    dzp_d = 1'b0;
                    neg_d = 1'b0;
                    if (div_zero) begin
                        // quotient all ones, remainder = dividend, no sign fix
                        hi_d    = rs1;
                        lo_d    = '1;
                        dzp_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (div_ovf) begin
                        hi_d    = '0;
                        lo_d    = rs1;
                        state_d = ST_DONE;
                    end else begin
                        hi_d    = '0;
                        lo_d    = op_is_div(op_in) ? mag_a : mag_b;
                        m_d     = op_is_div(op_in) ? mag_b : mag_a;
                        neg_d   = (op_in == OP_REM) ? neg_a : (neg_a ^ neg_b);
                        state_d = ST_CALC;
                    end
                end
            end

            ST_CALC: begin
                if (kill) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (is_div_q) begin
                        hi_d = div_ge ? add_s : add_x;
                        lo_d = {lo_q[XLEN-2:0], div_ge};
                    end else begin
                        hi_d = {add_co, add_s[XLEN-1:1]};
                        lo_d = {add_s[0], lo_q[XLEN-1:1]};
                    end
                    if (cnt_inc == CNT_W'(XLEN)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- outputs ----------------
    assign ready     = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE) && !kill;
    assign dbg_state = state_q;

    // r/dz show the new value during the done cycle and hold it afterwards;
    // a killed DONE never updates them.
    assign r_d  = done ? res_sel : r_q;
    assign dz_d = done ? dzp_q   : dz_q;
    assign r    = r_d;
    assign dz   = dz_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            dzp_q   <= 1'b0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            dzp_q   <= dzp_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at XLEN=32. Expected {dz, r} values and
// latencies are queued when an operation is driven and popped when done fires.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN) + 1;

    // ---------------- clock / reset ----------------
    logic            clk    = 1'b0;
    logic            rst    = 1'b0;
    logic            start  = 1'b0;
    logic            kill   = 1'b0;
    logic [2:0]      funct3 = 3'd0;
    logic [XLEN-1:0] rs1    = '0;
    logic [XLEN-1:0] rs2    = '0;
    logic            ready, busy, done, dz;
    logic [XLEN-1:0] r;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .kill      (kill),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .r         (r),
        .dz        (dz),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int              checks = 0;
    int              errors = 0;
    logic [XLEN:0]   exp_q[$];      // {dz, r}
    int              exp_lat_q[$];  // edges from accept to the edge capturing done
    logic [XLEN-1:0] last_r  = '0;
    logic            last_dz = 1'b0;

    // Reference model built on 64-bit arithmetic.
    function automatic logic [XLEN:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        up;
        logic [31:0]        res;
        logic               dzf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        dzf = 1'b0;
        res = '0;
        case (f)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; res = up[31:0]; end
            3'd1: begin sp = sa * sb; res = sp[63:32]; end
            3'd2: begin sp = sa * $signed({32'd0, b}); res = sp[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; res = up[63:32]; end
            3'd4: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; dzf = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
                else begin sp = sa / sb; res = sp[31:0]; end
            end
            3'd5: begin
                if (b == 0) begin res = 32'hFFFF_FFFF; dzf = 1'b1; end
                else res = a / b;
            end
            3'd6: begin
                if (b == 0) begin res = a; dzf = 1'b1; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
                else begin sp = sa % sb; res = sp[31:0]; end
            end
            default: begin
                if (b == 0) begin res = a; dzf = 1'b1; end
                else res = a % b;
            end
        endcase
        return {dzf, res};
    endfunction

    function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 1;
    endfunction

    // ---------------- driver ----------------
    // Drives one request, scrambles the inputs after the accepting edge, and
    // returns what the DUT reports at done together with its latency.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r_obs, output logic dz_obs,
                          output int lat, output logic seen);
        int k;
        @(negedge clk);
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        funct3 = f;
        rs1    = a;
        rs2    = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        rs1    = $urandom;
        rs2    = $urandom;
        seen   = 1'b0;
        lat    = 0;
        r_obs  = '0;
        dz_obs = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                seen   = 1'b1;
                lat    = i + 1;
                r_obs  = r;
                dz_obs = dz;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [XLEN:0] exp;
        int            exp_lat, k;
        logic          seen;
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({ready, busy, done, dz} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags ready/busy/done/dz=%b expected 1000", {ready, busy, done, dz});
        end
        checks++;
        if (r !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_r_state r=%h state=%0d expected r=0 state=0", r, dbg_state);
        end
        // Start is already high when reset drops: must be taken on the next edge.
        @(negedge clk);
        rst    = 1'b0;
        funct3 = 3'd0;
        rs1    = 32'd3;
        rs2    = 32'd5;
        start  = 1'b1;
        exp_q.push_back({1'b0, 32'd15});
        exp_lat_q.push_back(33);
        @(posedge clk);
        #1 start = 1'b0;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_accept busy=%b ready=%b expected busy=1 ready=0", busy, ready);
        end
        seen = 1'b0;
        k    = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin seen = 1'b1; k = i + 1; break; end
            @(posedge clk);
            #1;
        end
        exp     = exp_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        checks++;
        if (!seen || r !== exp[31:0] || k != exp_lat) begin
            errors++;
            $display("FAIL reset_first_op seen=%b r=%h lat=%0d expected r=%h lat=%0d", seen, r, k, exp[31:0], exp_lat);
        end
        last_r  = exp[31:0];
        last_dz = exp[32];
    endtask

    task automatic test_mul();
        logic [2:0]  f_t [4] = '{3'd0, 3'd3, 3'd1, 3'd2};
        logic [31:0] a_t [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b_t [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] e_t [4] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        logic [31:0] r_obs;
        logic        dz_obs, seen;
        int          lat, exp_lat;
        logic [XLEN:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, e_t[i]});
            exp_lat_q.push_back(33);
            run_op(f_t[i], a_t[i], b_t[i], r_obs, dz_obs, lat, seen);
            exp     = exp_q.pop_front();
            exp_lat = exp_lat_q.pop_front();
            checks++;
            if (!seen || r_obs !== exp[31:0] || dz_obs !== exp[32]) begin
                errors++;
                $display("FAIL mul[%0d] seen=%b r=%h dz=%b expected r=%h dz=%b", i, seen, r_obs, dz_obs, exp[31:0], exp[32]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL mul_latency[%0d] got %0d expected %0d", i, lat, exp_lat);
            end
            last_r  = exp[31:0];
            last_dz = exp[32];
        end
    endtask

    task automatic test_div();
        logic [2:0]  f_t [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] a_t [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        logic [31:0] b_t [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] e_t [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
        logic [31:0] r_obs;
        logic        dz_obs, seen;
        int          lat, exp_lat;
        logic [XLEN:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({1'b0, e_t[i]});
            exp_lat_q.push_back(33);
            run_op(f_t[i], a_t[i], b_t[i], r_obs, dz_obs, lat, seen);
            exp     = exp_q.pop_front();
            exp_lat = exp_lat_q.pop_front();
            checks++;
            if (!seen || r_obs !== exp[31:0] || dz_obs !== exp[32]) begin
                errors++;
                $display("FAIL div[%0d] seen=%b r=%h dz=%b expected r=%h dz=%b", i, seen, r_obs, dz_obs, exp[31:0], exp[32]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL div_latency[%0d] got %0d expected %0d", i, lat, exp_lat);
            end
            last_r  = exp[31:0];
            last_dz = exp[32];
        end
    endtask

    // Divide by zero and signed overflow both finish one edge after accept.
    task automatic test_fast_path();
        logic [2:0]  f_t [6] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6};
        logic [31:0] a_t [6] = '{32'd100, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] b_t [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] e_t [6] = '{32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        logic        d_t [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [31:0] r_obs;
        logic        dz_obs, seen;
        int          lat, exp_lat;
        logic [XLEN:0] exp;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back({d_t[i], e_t[i]});
            exp_lat_q.push_back(1);
            run_op(f_t[i], a_t[i], b_t[i], r_obs, dz_obs, lat, seen);
            exp     = exp_q.pop_front();
            exp_lat = exp_lat_q.pop_front();
            checks++;
            if (!seen || r_obs !== exp[31:0] || dz_obs !== exp[32]) begin
                errors++;
                $display("FAIL fast[%0d] seen=%b r=%h dz=%b expected r=%h dz=%b", i, seen, r_obs, dz_obs, exp[31:0], exp[32]);
            end
            checks++;
            if (lat != exp_lat) begin
                errors++;
                $display("FAIL fast_latency[%0d] got %0d expected %0d", i, lat, exp_lat);
            end
            last_r  = exp[31:0];
            last_dz = exp[32];
            // dz from a zero divide must persist with r after the pulse.
            if (i == 0) begin
                @(posedge clk);
                #1;
                checks++;
                if (r !== last_r || dz !== last_dz || done !== 1'b0) begin
                    errors++;
                    $display("FAIL fast_hold r=%h dz=%b done=%b expected r=%h dz=%b done=0", r, dz, done, last_r, last_dz);
                end
            end
        end
    endtask

    task automatic test_kill();
        int n_done;
        // kill during CALC cycle 10
        @(negedge clk);
        funct3 = 3'd0;
        rs1    = 32'd123;
        rs2    = 32'd456;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_done = 0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || n_done != 0) begin
            errors++;
            $display("FAIL kill_calc ready=%b busy=%b done=%b early_done=%0d expected 1 0 0 0", ready, busy, done, n_done);
        end
        checks++;
        if (r !== last_r || dz !== last_dz) begin
            errors++;
            $display("FAIL kill_calc_hold r=%h dz=%b expected r=%h dz=%b", r, dz, last_r, last_dz);
        end
        // kill during DONE of a fast-path op
        @(negedge clk);
        funct3 = 3'd5;
        rs1    = 32'd9;
        rs2    = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        kill = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || r !== last_r || dz !== last_dz) begin
            errors++;
            $display("FAIL kill_done done=%b busy=%b r=%h dz=%b expected done=0 busy=1 r=%h dz=%b", done, busy, r, dz, last_r, last_dz);
        end
        @(posedge clk);
        #1 kill = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || r !== last_r) begin
            errors++;
            $display("FAIL kill_done_idle ready=%b done=%b r=%h expected ready=1 done=0 r=%h", ready, done, r, last_r);
        end
        // kill in IDLE blocks a simultaneous start
        @(negedge clk);
        funct3 = 3'd0;
        rs1    = 32'd1;
        rs2    = 32'd1;
        start  = 1'b1;
        kill   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        checks++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL kill_idle ready=%b busy=%b expected ready=1 busy=0", ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [XLEN:0] exp;
        int            exp_lat, lat, extra;
        logic          seen;
        logic [31:0]   r_obs;
        exp_q.push_back({1'b0, 32'd142});
        exp_lat_q.push_back(33);
        @(negedge clk);
        funct3 = 3'd5;
        rs1    = 32'd1000;
        rs2    = 32'd7;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen  = 1'b0;
        lat   = 0;
        extra = 0;
        r_obs = '0;
        for (int c = 0; c <= 60; c++) begin
            if (done) begin
                if (!seen) begin seen = 1'b1; lat = c + 1; r_obs = r; end
                else extra++;
            end
            // A second request while busy must be dropped, not queued.
            if (c == 4) begin
                funct3 = 3'd0;
                rs1    = 32'd2;
                rs2    = 32'd2;
                start  = 1'b1;
            end
            if (c == 5) start = 1'b0;
            @(posedge clk);
            #1;
        end
        exp     = exp_q.pop_front();
        exp_lat = exp_lat_q.pop_front();
        checks++;
        if (!seen || r_obs !== exp[31:0] || lat != exp_lat) begin
            errors++;
            $display("FAIL busy_start seen=%b r=%h lat=%0d expected r=%h lat=%0d", seen, r_obs, lat, exp[31:0], exp_lat);
        end
        checks++;
        if (extra != 0 || ready !== 1'b1 || r !== exp[31:0]) begin
            errors++;
            $display("FAIL busy_start_dropped extra_done=%0d ready=%b r=%h expected 0 1 %h", extra, ready, r, exp[31:0]);
        end
        last_r  = exp[31:0];
        last_dz = exp[32];
    endtask

    task automatic test_rst_midop();
        int n_done;
        @(negedge clk);
        funct3 = 3'd3;
        rs1    = $urandom;
        rs2    = $urandom;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({ready, busy, done, dz} !== 4'b1000 || r !== '0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_midop ready/busy/done/dz=%b r=%h state=%0d expected 1000 r=0 state=0", {ready, busy, done, dz}, r, dbg_state);
        end
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) n_done++;
        end
        checks++;
        if (n_done != 0 || ready !== 1'b1 || r !== '0) begin
            errors++;
            $display("FAIL rst_midop_after done_count=%0d ready=%b r=%h expected 0 1 0", n_done, ready, r);
        end
        last_r  = '0;
        last_dz = 1'b0;
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, r_obs;
        logic        dz_obs, seen;
        int          lat, exp_lat, sel;
        logic [XLEN:0] exp;
        for (int i = 0; i < 24; i++) begin
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) b = -32'($urandom_range(1, 15));
            exp_q.push_back(model(f, a, b));
            exp_lat_q.push_back(lat_of(f, a, b));
            run_op(f, a, b, r_obs, dz_obs, lat, seen);
            exp     = exp_q.pop_front();
            exp_lat = exp_lat_q.pop_front();
            checks++;
            if (!seen || r_obs !== exp[31:0] || dz_obs !== exp[32] || lat != exp_lat) begin
                errors++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h seen=%b r=%h dz=%b lat=%0d expected r=%h dz=%b lat=%0d",
                         i, f, a, b, seen, r_obs, dz_obs, lat, exp[31:0], exp[32], exp_lat);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_kill();
        test_back_to_back();
        test_rst_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
